// File: rtl/wb_pkg.sv
// Shared opcode constants, queue-entry layout and decode helpers for the
// write-back commit queue.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_REG_AW = 5;

    localparam logic [5:0] OP_LOAD    = 6'b010001;
    localparam logic [5:0] OP_BR      = 6'b100000;
    localparam logic [5:0] OP_JMP     = 6'b100001;
    localparam logic [1:0] OP_CLS_ALU = 2'b00;

    typedef struct packed {
        logic [5:0]           op;
        logic                 ife;
        logic [WB_REG_AW-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } entry_t;

    function automatic logic is_reg_op(input logic [5:0] op);
        return (op[5:4] == OP_CLS_ALU) || (op == OP_LOAD);
    endfunction

    function automatic logic is_redirect(input logic [5:0] op,
                                         input logic       ife);
        return ((op == OP_BR) && ife) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry in-order queue with push, pop and a clear that wins over both.
// WB_BYPASS_EN exposes all slots in age order (index 0 = head).
module wb_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0],
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    input  logic          clear,
    output T              head,
    output logic [CW-1:0] count
`ifdef WB_BYPASS_EN
    ,
    output T              ordered_o [DEPTH]
`endif
);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = nxt(wr_q);
            end
            if (pop) begin
                rd_d = nxt(rd_q);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

`ifdef WB_BYPASS_EN
    always_comb begin
        int idx;
        for (int i = 0; i < DEPTH; i++) begin
            idx = int'(rd_q) + i;
            if (idx >= DEPTH) idx = idx - DEPTH;
            ordered_o[i] = mem_q[PW'(idx)];
        end
    end
`endif

endmodule

// File: rtl/wb_commit_queue.sv
// In-order write-back commit queue: registered RF writes and PC redirects,
// squashes younger entries on redirect. Optional forwarding via WB_BYPASS_EN.
module wb_commit_queue #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic              in_ife,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wb_stall,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wdata,
    output logic [31:0]       retire_cnt
`ifdef WB_BYPASS_EN
    ,
    output logic              byp_valid,
    output logic [REG_AW-1:0] byp_rd,
    output logic [DATA_W-1:0] byp_data
`endif
);

    import wb_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [5:0]        op;
        logic              ife;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } q_entry_t;

    q_entry_t      push_ent;
    q_entry_t      head;
    logic [CW-1:0] count;
    logic          push, pop, squash;

    logic              reg_we_q, reg_we_d;
    logic [REG_AW-1:0] reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic              pc_we_q, pc_we_d;
    logic [DATA_W-1:0] pc_wdata_q, pc_wdata_d;
    logic [31:0]       retire_cnt_q, retire_cnt_d;

`ifdef WB_BYPASS_EN
    q_entry_t ordered [DEPTH];
`endif

    wb_fifo #(
        .DEPTH (DEPTH),
        .T     (q_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .clear     (squash),
        .head      (head),
        .count     (count)
`ifdef WB_BYPASS_EN
        ,
        .ordered_o (ordered)
`endif
    );

    // Ready looks only at the registered count: no pass-through when full.
    always_comb begin
        push_ent = '{op: in_op, ife: in_ife, rd: in_rd, data: in_data};
        in_ready = (count < CW'(DEPTH));
        push     = in_valid && in_ready;
        pop      = (count != '0) && !wb_stall;
        squash   = pop && is_redirect(head.op, head.ife);
    end

    always_comb begin
        reg_we_d     = 1'b0;
        pc_we_d      = 1'b0;
        reg_waddr_d  = reg_waddr_q;
        reg_wdata_d  = reg_wdata_q;
        pc_wdata_d   = pc_wdata_q;
        retire_cnt_d = retire_cnt_q;
        if (pop) begin
            reg_we_d     = is_reg_op(head.op) && (head.rd != '0);
            pc_we_d      = is_redirect(head.op, head.ife);
            reg_waddr_d  = head.rd;
            reg_wdata_d  = head.data;
            pc_wdata_d   = head.data;
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we_q     <= 1'b0;
            reg_waddr_q  <= '0;
            reg_wdata_q  <= '0;
            pc_we_q      <= 1'b0;
            pc_wdata_q   <= '0;
            retire_cnt_q <= '0;
        end else begin
            reg_we_q     <= reg_we_d;
            reg_waddr_q  <= reg_waddr_d;
            reg_wdata_q  <= reg_wdata_d;
            pc_we_q      <= pc_we_d;
            pc_wdata_q   <= pc_wdata_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign reg_we     = reg_we_q;
    assign reg_waddr  = reg_waddr_q;
    assign reg_wdata  = reg_wdata_q;
    assign pc_we      = pc_we_q;
    assign pc_wdata   = pc_wdata_q;
    assign retire_cnt = retire_cnt_q;

`ifdef WB_BYPASS_EN
    // Youngest matching entry wins, so scan from head and keep the last hit.
    always_comb begin
        byp_valid = 1'b0;
        byp_rd    = '0;
        byp_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && is_reg_op(ordered[i].op)
                && (ordered[i].rd != '0)) begin
                byp_valid = 1'b1;
                byp_rd    = ordered[i].rd;
                byp_data  = ordered[i].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue: table of single-instruction vectors, directed
// squash/stall/reset sequences and a random burst checked by a queue model.
module tb_wb_commit_queue;

    import wb_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic        in_ife = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_data = '0;
    logic        wb_stall = 1'b0;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        pc_we;
    logic [31:0] pc_wdata;
    logic [31:0] retire_cnt;
`ifdef WB_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;
`endif

    wb_commit_queue #(.DATA_W(32), .REG_AW(5), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_ife     (in_ife),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .wb_stall   (wb_stall),
        .reg_we     (reg_we),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .pc_we      (pc_we),
        .pc_wdata   (pc_wdata),
        .retire_cnt (retire_cnt)
`ifdef WB_BYPASS_EN
        ,
        .byp_valid  (byp_valid),
        .byp_rd     (byp_rd),
        .byp_data   (byp_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Scoreboard: model queue plus expected output record per commit
    typedef struct {
        logic        rwe;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        pwe;
        logic [31:0] pdata;
    } exp_t;

    entry_t      mq[$];
    exp_t        exp_q[$];
    logic [31:0] m_ret = '0;
    bit          mon_en = 1'b0;
    bit          m_rdy, m_pop, m_push;
    entry_t      m_h;
    exp_t        m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            m_ret = '0;
        end else begin
            m_rdy  = mq.size() < DEPTH;
            m_pop  = (mq.size() > 0) && !wb_stall;
            m_push = in_valid && m_rdy;
            if (m_pop) begin
                m_h = mq.pop_front();
                m_e.rwe = ((m_h.op[5:4] == 2'b00) || (m_h.op == OP_LOAD))
                          && (m_h.rd != 5'd0);
                m_e.pwe = ((m_h.op == OP_BR) && m_h.ife) || (m_h.op == OP_JMP);
                m_e.waddr = m_h.rd;
                m_e.wdata = m_h.data;
                m_e.pdata = m_h.data;
                exp_q.push_back(m_e);
                m_ret = m_ret + 32'd1;
                if (m_e.pwe) begin
                    mq.delete();
                    m_push = 1'b0;
                end
            end
            if (m_push) mq.push_back('{in_op, in_ife, in_rd, in_data});
        end
    end

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("sb_in_ready", {31'd0, in_ready}, {31'd0, mq.size() < DEPTH});
            chk("sb_retire", retire_cnt, m_ret);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("sb_reg_we", {31'd0, reg_we}, {31'd0, mon_e.rwe});
                chk("sb_pc_we", {31'd0, pc_we}, {31'd0, mon_e.pwe});
                if (mon_e.rwe) begin
                    chk("sb_waddr", {27'd0, reg_waddr}, {27'd0, mon_e.waddr});
                    chk("sb_wdata", reg_wdata, mon_e.wdata);
                end
                if (mon_e.pwe) chk("sb_pc_wdata", pc_wdata, mon_e.pdata);
            end else begin
                chk("sb_idle_strobes", {30'd0, reg_we, pc_we}, 32'd0);
            end
        end
    end

    typedef struct {
        logic [5:0]  op;
        logic        ife;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rwe;
        logic        pwe;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] tbl_ret;
    logic [31:0] base;
    logic [5:0]  ops[6];

    task automatic drive(input logic v, input logic [5:0] op, input logic ife,
                         input logic [4:0] rd, input logic [31:0] d);
        in_valid = v;
        in_op    = op;
        in_ife   = ife;
        in_rd    = rd;
        in_data  = d;
    endtask

    initial begin
        vecs[0] = '{6'h05, 1'b0, 5'd3,  32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[1] = '{6'h11, 1'b0, 5'd0,  32'h0000_1234, 1'b0, 1'b0};
        vecs[2] = '{6'h20, 1'b0, 5'd0,  32'h0000_0040, 1'b0, 1'b0};
        vecs[3] = '{6'h20, 1'b1, 5'd0,  32'h0000_0040, 1'b0, 1'b1};
        vecs[4] = '{6'h21, 1'b0, 5'd2,  32'h0000_0080, 1'b0, 1'b1};
        vecs[5] = '{6'h11, 1'b0, 5'd7,  32'h0000_0055, 1'b1, 1'b0};
        vecs[6] = '{6'h3F, 1'b1, 5'd9,  32'h1111_2222, 1'b0, 1'b0};
        vecs[7] = '{6'h0A, 1'b0, 5'd0,  32'h3333_4444, 1'b0, 1'b0};
        vecs[8] = '{6'h12, 1'b0, 5'd4,  32'h5555_6666, 1'b0, 1'b0};
        vecs[9] = '{6'h00, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0};
        ops = '{6'h05, 6'h11, 6'h20, 6'h21, 6'h3F, 6'h12};

        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_strobes", {30'd0, reg_we, pc_we}, 32'd0);
        chk("rst_waddr", {27'd0, reg_waddr}, 32'd0);
        chk("rst_wdata", reg_wdata, 32'd0);
        chk("rst_pc_wdata", pc_wdata, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        #5 rst_n = 1'b1;
        mon_en = 1'b1;

        tbl_ret = 32'd0;
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].ife, vecs[i].rd, vecs[i].data);
            @(posedge clk);
            @(negedge clk);
            drive(1'b0, 6'h00, 1'b0, 5'd0, 32'd0);
            @(posedge clk);
            #1;
            tbl_ret = tbl_ret + 32'd1;
            chk("tbl_reg_we", {31'd0, reg_we}, {31'd0, vecs[i].rwe});
            chk("tbl_pc_we", {31'd0, pc_we}, {31'd0, vecs[i].pwe});
            if (vecs[i].rwe) begin
                chk("tbl_waddr", {27'd0, reg_waddr}, {27'd0, vecs[i].rd});
                chk("tbl_wdata", reg_wdata, vecs[i].data);
            end
            if (vecs[i].pwe) chk("tbl_pc_wdata", pc_wdata, vecs[i].data);
            chk("tbl_retire", retire_cnt, tbl_ret);
            @(posedge clk);
            #1 chk("tbl_one_shot", {30'd0, reg_we, pc_we}, 32'd0);
        end

        // Jump with full queue; third push refused, ALU entry squashed
        @(negedge clk);
        wb_stall = 1'b1;
        drive(1'b1, 6'h21, 1'b0, 5'd0, 32'h80);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 6'h05, 1'b0, 5'd5, 32'h1111);
        @(posedge clk);
        @(negedge clk);
        chk("sq_full_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 6'h05, 1'b0, 5'd6, 32'h2222);
        wb_stall = 1'b0;
        base = m_ret;
        @(posedge clk);
        #1;
        chk("sq_pc_we", {31'd0, pc_we}, 32'd1);
        chk("sq_pc_wdata", pc_wdata, 32'h80);
        chk("sq_no_reg_we", {31'd0, reg_we}, 32'd0);
        @(negedge clk);
        drive(1'b0, 6'h00, 1'b0, 5'd0, 32'd0);
        chk("sq_ready_after", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("sq_retire", retire_cnt, base + 32'd1);

        // Jump alone; push at the commit edge is discarded
        @(negedge clk);
        wb_stall = 1'b1;
        drive(1'b1, 6'h21, 1'b0, 5'd0, 32'h90);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 6'h05, 1'b0, 5'd8, 32'h3333);
        wb_stall = 1'b0;
        base = m_ret;
        @(posedge clk);
        #1 chk("sq2_pc_wdata", pc_wdata, 32'h90);
        @(negedge clk);
        drive(1'b0, 6'h00, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1 chk("sq2_push_dropped", {31'd0, reg_we}, 32'd0);
        @(negedge clk);
        chk("sq2_retire", retire_cnt, base + 32'd1);

        // Stall for 5 edges while offering 3 entries
        @(negedge clk);
        wb_stall = 1'b1;
        drive(1'b1, 6'h05, 1'b0, 5'd1, 32'hA1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 6'h05, 1'b0, 5'd2, 32'hA2);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 6'h05, 1'b0, 5'd3, 32'hA3);
        chk("stall_full", {31'd0, in_ready}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("stall_still_full", {31'd0, in_ready}, 32'd0);
        chk("stall_no_we", {30'd0, reg_we, pc_we}, 32'd0);
        wb_stall = 1'b0;
        @(posedge clk);
        #1 chk("stall_c1", {26'd0, reg_we, reg_waddr}, {26'd0, 1'b1, 5'd1});
        @(posedge clk);
        #1 chk("stall_c2", {26'd0, reg_we, reg_waddr}, {26'd0, 1'b1, 5'd2});
        @(negedge clk);
        drive(1'b0, 6'h00, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1 chk("stall_c3", {26'd0, reg_we, reg_waddr}, {26'd0, 1'b1, 5'd3});
        chk("stall_c3_data", reg_wdata, 32'hA3);

        // Random burst checked by the scoreboard
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), ops[$urandom_range(0, 5)],
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  $urandom);
            wb_stall = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        drive(1'b0, 6'h00, 1'b0, 5'd0, 32'd0);
        wb_stall = 1'b0;
        repeat (4) @(negedge clk);

        // Asynchronous reset with two entries queued and a strobe active
        wb_stall = 1'b1;
        drive(1'b1, 6'h05, 1'b0, 5'd10, 32'hB0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 6'h05, 1'b0, 5'd11, 32'hB1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 6'h00, 1'b0, 5'd0, 32'd0);
        wb_stall = 1'b0;
        @(posedge clk);
        #1 chk("pre_reset_we", {31'd0, reg_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_strobes", {30'd0, reg_we, pc_we}, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ar_retire", retire_cnt, 32'd0);
        chk("ar_waddr", {27'd0, reg_waddr}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ar_queue_gone", {30'd0, reg_we, pc_we}, 32'd0);
        chk("ar_ready_after", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
